// File: rtl/unidade_controle_pkg.sv
// State codes, control-word layout and the Moore output decode shared by the
// game controller and any display/debug decoder that shows db_estado.
// Build option: define UNIDADE_CONTROLE_TIMEOUT_EN to enable the play timeout.
package unidade_controle_pkg;

    localparam int unsigned ESTADO_W = 4;

    // Numeric state codes, also the values reported on db_estado
    localparam logic [ESTADO_W-1:0] ST_INICIAL          = 4'h0;
    localparam logic [ESTADO_W-1:0] ST_PREPARACAO       = 4'h1;
    localparam logic [ESTADO_W-1:0] ST_INICIO_RODADA    = 4'h2;
    localparam logic [ESTADO_W-1:0] ST_ESPERA_JOGADA    = 4'h3;
    localparam logic [ESTADO_W-1:0] ST_REGISTRA         = 4'h4;
    localparam logic [ESTADO_W-1:0] ST_COMPARACAO       = 4'h5;
    localparam logic [ESTADO_W-1:0] ST_PROXIMA_POSICAO  = 4'h6;
    localparam logic [ESTADO_W-1:0] ST_PROXIMA_ESCRITA  = 4'h7;
    localparam logic [ESTADO_W-1:0] ST_ESPERA_ESCRITA   = 4'h8;
    localparam logic [ESTADO_W-1:0] ST_REGISTRA_ESCRITA = 4'h9;
    localparam logic [ESTADO_W-1:0] ST_ESCREVE          = 4'hA;
    localparam logic [ESTADO_W-1:0] ST_PROXIMA_RODADA   = 4'hB;
    localparam logic [ESTADO_W-1:0] ST_FIM_ACERTOU      = 4'hC;
    localparam logic [ESTADO_W-1:0] ST_FIM_ERROU        = 4'hD;
    localparam logic [ESTADO_W-1:0] ST_FIM_TIMEOUT      = 4'hE;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL          = ST_INICIAL,
        PREPARACAO       = ST_PREPARACAO,
        INICIO_RODADA    = ST_INICIO_RODADA,
        ESPERA_JOGADA    = ST_ESPERA_JOGADA,
        REGISTRA         = ST_REGISTRA,
        COMPARACAO       = ST_COMPARACAO,
        PROXIMA_POSICAO  = ST_PROXIMA_POSICAO,
        PROXIMA_ESCRITA  = ST_PROXIMA_ESCRITA,
        ESPERA_ESCRITA   = ST_ESPERA_ESCRITA,
        REGISTRA_ESCRITA = ST_REGISTRA_ESCRITA,
        ESCREVE          = ST_ESCREVE,
        PROXIMA_RODADA   = ST_PROXIMA_RODADA,
        FIM_ACERTOU      = ST_FIM_ACERTOU,
        FIM_ERROU        = ST_FIM_ERROU,
        FIM_TIMEOUT      = ST_FIM_TIMEOUT
    } estado_t;

    // Datapath controls followed by game status, all active-high
    typedef struct packed {
        logic zera_e;
        logic conta_e;
        logic zera_rod;
        logic conta_rod;
        logic zera_t;
        logic conta_t;
        logic zera_r;
        logic registra_r;
        logic we;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } controle_t;

    // True for the three terminal states that wait for a restart
    function automatic logic eh_fim(input estado_t estado);
        return (estado == FIM_ACERTOU) || (estado == FIM_ERROU) ||
               (estado == FIM_TIMEOUT);
    endfunction

    // Moore decode: control word is a pure function of the state
    function automatic controle_t decodifica(input estado_t estado);
        controle_t c;
        c = '0;
        case (estado)
            PREPARACAO: begin
                c.zera_e   = 1'b1;
                c.zera_rod = 1'b1;
                c.zera_r   = 1'b1;
                c.zera_t   = 1'b1;
            end
            INICIO_RODADA: begin
                c.zera_e = 1'b1;
                c.zera_t = 1'b1;
            end
            ESPERA_JOGADA, ESPERA_ESCRITA: begin
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                c.conta_t = 1'b1;
`else
                c.conta_t = 1'b0;
`endif
            end
            REGISTRA: begin
                c.registra_r = 1'b1;
                c.zera_t     = 1'b1;
            end
            PROXIMA_POSICAO: begin
                c.conta_e = 1'b1;
            end
            PROXIMA_ESCRITA: begin
                c.conta_e = 1'b1;
                c.zera_t  = 1'b1;
            end
            REGISTRA_ESCRITA: begin
                c.registra_r = 1'b1;
            end
            ESCREVE: begin
                c.we = 1'b1;
            end
            PROXIMA_RODADA: begin
                c.conta_rod = 1'b1;
            end
            FIM_ACERTOU: begin
                c.pronto  = 1'b1;
                c.acertou = 1'b1;
            end
            FIM_ERROU: begin
                c.pronto = 1'b1;
                c.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                c.pronto = 1'b1;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                c.timeout = 1'b1;
`else
                c.timeout = 1'b0;
`endif
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/unidade_controle_exp7.sv
// Control unit of the memory game: plays back the stored sequence round by
// round, appends one new play per round and reports hit / miss / timeout.
// Moore machine; the control word is registered alongside the state so every
// output is a flop that always equals decodifica(current state).
// Build option: define UNIDADE_CONTROLE_TIMEOUT_EN to act on fimT.
module unidade_controle_exp7
    import unidade_controle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       fimRod,
    input  logic       fimT,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraRod,
    output logic       contaRod,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraR,
    output logic       registraR,
    output logic       we,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t   estado;
    estado_t   estado_next;
    controle_t ctrl_q;
    controle_t ctrl_next;
    logic      espera_expirou;

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    assign espera_expirou = fimT;
`else
    // Timeout disabled: the flag is accepted on the port but never acted on
    logic unused_fim_t;
    assign unused_fim_t   = fimT;
    assign espera_expirou = 1'b0;
`endif

    // State register and registered control word; reset is immediate
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
            ctrl_q <= '0;
        end else begin
            estado <= estado_next;
            ctrl_q <= ctrl_next;
        end
    end

    // Next-state logic; outputs follow from the state being entered
    always_comb begin
        estado_next = estado;
        ctrl_next   = '0;

        case (estado)
            INICIAL: begin
                if (iniciar) begin
                    estado_next = PREPARACAO;
                end
            end

            PREPARACAO: begin
                estado_next = INICIO_RODADA;
            end

            INICIO_RODADA: begin
                estado_next = ESPERA_JOGADA;
            end

            // A play arriving together with the timeout still counts
            ESPERA_JOGADA: begin
                if (jogada_feita) begin
                    estado_next = REGISTRA;
                end else if (espera_expirou) begin
                    estado_next = FIM_TIMEOUT;
                end
            end

            REGISTRA: begin
                estado_next = COMPARACAO;
            end

            COMPARACAO: begin
                if (!igual) begin
                    estado_next = FIM_ERROU;
                end else if (!enderecoIgualRodada) begin
                    estado_next = PROXIMA_POSICAO;
                end else if (fimRod) begin
                    estado_next = FIM_ACERTOU;
                end else begin
                    estado_next = PROXIMA_ESCRITA;
                end
            end

            PROXIMA_POSICAO: begin
                estado_next = ESPERA_JOGADA;
            end

            PROXIMA_ESCRITA: begin
                estado_next = ESPERA_ESCRITA;
            end

            ESPERA_ESCRITA: begin
                if (jogada_feita) begin
                    estado_next = REGISTRA_ESCRITA;
                end else if (espera_expirou) begin
                    estado_next = FIM_TIMEOUT;
                end
            end

            REGISTRA_ESCRITA: begin
                estado_next = ESCREVE;
            end

            ESCREVE: begin
                estado_next = PROXIMA_RODADA;
            end

            PROXIMA_RODADA: begin
                estado_next = INICIO_RODADA;
            end

            FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: begin
                if (iniciar) begin
                    estado_next = PREPARACAO;
                end
            end

            // Unused code 4'hF falls back to the idle state
            default: begin
                estado_next = INICIAL;
            end
        endcase

        ctrl_next = decodifica(estado_next);
    end

    // Output wiring from the registered control word
    assign zeraE     = ctrl_q.zera_e;
    assign contaE    = ctrl_q.conta_e;
    assign zeraRod   = ctrl_q.zera_rod;
    assign contaRod  = ctrl_q.conta_rod;
    assign zeraT     = ctrl_q.zera_t;
    assign contaT    = ctrl_q.conta_t;
    assign zeraR     = ctrl_q.zera_r;
    assign registraR = ctrl_q.registra_r;
    assign we        = ctrl_q.we;
    assign pronto    = ctrl_q.pronto;
    assign acertou   = ctrl_q.acertou;
    assign errou     = ctrl_q.errou;
    assign timeout   = ctrl_q.timeout;
    assign db_estado = 4'(estado);

endmodule

// File: tb/tb_unidade_controle_exp7.sv
// Bench for unidade_controle_exp7: a behavioural datapath and a scripted
// player drive the controller through whole games; the predicted game outcome
// and the per-state output table are checked every cycle.
module tb_unidade_controle_exp7;

    localparam int TLIM = 20;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada_feita;
    logic       igual;
    logic       enderecoIgualRodada;
    logic       fimRod;
    logic       fimT;
    logic       zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR, we;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [12:0] saidas;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural datapath: memory, address/round/timeout counters, play register
    logic [3:0] mem [16];
    logic [3:0] seq [16];
    logic [3:0] e_cnt, rod_cnt, r_reg, jogada;
    int         t_cnt;

    unidade_controle_exp7 dut (
        .clock               (clock),
        .reset               (reset),
        .iniciar             (iniciar),
        .jogada_feita        (jogada_feita),
        .igual               (igual),
        .enderecoIgualRodada (enderecoIgualRodada),
        .fimRod              (fimRod),
        .fimT                (fimT),
        .zeraE               (zeraE),
        .contaE              (contaE),
        .zeraRod             (zeraRod),
        .contaRod            (contaRod),
        .zeraT               (zeraT),
        .contaT              (contaT),
        .zeraR               (zeraR),
        .registraR           (registraR),
        .we                  (we),
        .pronto              (pronto),
        .acertou             (acertou),
        .errou               (errou),
        .timeout             (timeout),
        .db_estado           (db_estado)
    );

    assign saidas = {zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR,
                     registraR, we, pronto, acertou, errou, timeout};

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: obtido 0x%0h esperado 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output table per state code, in the bit order of 'saidas'
    function automatic logic [12:0] saidas_esperadas(input logic [3:0] code);
        case (code)
            4'h1:       return 13'b1010101000000;
            4'h2:       return 13'b1000100000000;
            4'h3, 4'h8: return {5'b0, TMO_EN, 7'b0};
            4'h4:       return 13'b0000100100000;
            4'h6:       return 13'b0100000000000;
            4'h7:       return 13'b0100100000000;
            4'h9:       return 13'b0000000100000;
            4'hA:       return 13'b0000000010000;
            4'hB:       return 13'b0001000000000;
            4'hC:       return 13'b0000000001100;
            4'hD:       return 13'b0000000001010;
            4'hE:       return {12'b000000000100, TMO_EN};
            default:    return 13'b0;
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Pull reset between two edges and look before the next edge
    task automatic reset_assincrono();
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_eq("reset_assinc_estado", 32'(db_estado), 32'h0);
        check_eq("reset_assinc_saidas", 32'(saidas), 32'h0);
        iniciar      = 1'b0;
        jogada_feita = 1'b0;
        fimT         = 1'b0;
        @(negedge clock);
        check_eq("reset_mantido", 32'(db_estado), 32'h0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("pos_reset_inicial", 32'(db_estado), 32'h0);
    endtask

    // One game. err_*: wrong play at (round, position); stall_*: no play there,
    // fimT raised instead; abort_code: pull async reset once that state shows.
    task automatic run_game(input int err_r, input int err_p, input int stall_r, input int stall_p,
                            input int abort_code, output logic [3:0] final_code, output int we_count);
        int         pr, pp, delay, stall_cycles;
        bit         wphase, done, have_expect;
        logic [3:0] code, expect_next;
        for (int i = 0; i < 16; i++) begin
            seq[i] = 4'($urandom_range(0, 15));
            mem[i] = 4'($urandom_range(0, 15));
        end
        mem[0] = seq[0];
        pr = 0; pp = 0; wphase = 1'b0; delay = $urandom_range(0, 3);
        stall_cycles = 0; done = 1'b0; have_expect = 1'b0; expect_next = 4'h0;
        we_count = 0; final_code = 4'h0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clock);
            code = db_estado;
            check_eq("saidas_estado", 32'(saidas), 32'(saidas_esperadas(code)));
            if (have_expect) begin
                check_eq("prioridade_jogada", 32'(code), 32'(expect_next));
                have_expect = 1'b0;
            end
            if (cyc == 1) check_eq("partida", 32'(code), 32'h1);
            if (cyc > 0 && code >= 4'hC && code <= 4'hE) begin
                final_code = code;
                done = 1'b1;
            end else if (cyc > 0 && abort_code >= 0 && int'(code) == abort_code) begin
                reset_assincrono();
                final_code = db_estado;
                done = 1'b1;
            end else begin
                iniciar             = (cyc == 0);
                igual               = (r_reg == mem[e_cnt]);
                enderecoIgualRodada = (e_cnt == rod_cnt);
                fimRod              = (rod_cnt == 4'd15);
                fimT                = (t_cnt >= TLIM);
                jogada_feita        = 1'b0;
                if (code == 4'h3 || code == 4'h8) begin
                    if (!wphase && pr == stall_r && pp == stall_p) begin
                        stall_cycles++;
                        if (stall_cycles >= 3) fimT = 1'b1;
                        if (!TMO_EN && stall_cycles >= 4) begin
                            check_eq("espera_sem_timeout", 32'(code), 32'h3);
                            check_eq("contaT_sem_timeout", 32'(contaT), 32'h0);
                        end
                        if (!TMO_EN && stall_cycles > 10) begin
                            final_code = code;
                            done = 1'b1;
                        end
                    end else if (delay > 0) begin
                        delay--;
                    end else begin
                        jogada_feita = 1'b1;
                        jogada = wphase ? seq[4'(pr + 1)] : seq[4'(pp)];
                        if (!wphase && pr == err_r && pp == err_p)
                            jogada = seq[4'(pp)] ^ 4'($urandom_range(1, 15));
                        if ($urandom_range(0, 3) == 0) begin
                            fimT        = 1'b1;
                            have_expect = 1'b1;
                            expect_next = (code == 4'h3) ? 4'h4 : 4'h9;
                        end
                        if (wphase) begin
                            wphase = 1'b0;
                            pr++;
                            pp = 0;
                        end else if (pp < pr) begin
                            pp++;
                        end else if (pr < 15) begin
                            wphase = 1'b1;
                        end
                        delay = $urandom_range(0, 4);
                    end
                end
                // Datapath reacts at the coming edge to the controls now shown
                if (we) begin
                    mem[e_cnt] = r_reg;
                    we_count++;
                end
                if (zeraE) e_cnt = 4'h0; else if (contaE) e_cnt = e_cnt + 4'h1;
                if (zeraRod) rod_cnt = 4'h0; else if (contaRod) rod_cnt = rod_cnt + 4'h1;
                if (zeraT) t_cnt = 0; else if (contaT) t_cnt++;
                if (zeraR) r_reg = 4'h0; else if (registraR) r_reg = jogada;
            end
        end
        check_eq("orcamento_ciclos", 32'(done), 32'h1);
        iniciar      = 1'b0;
        jogada_feita = 1'b0;
        fimT         = 1'b0;
    endtask

    initial begin
        logic [3:0] fc;
        int         wc, mode, r, p;
        reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0;
        enderecoIgualRodada = 1'b0; fimRod = 1'b0; fimT = 1'b0;
        e_cnt = 4'h0; rod_cnt = 4'h0; r_reg = 4'h0; jogada = 4'h0; t_cnt = 0;

        #12;
        check_eq("reset_estado", 32'(db_estado), 32'h0);
        check_eq("reset_saidas", 32'(saidas), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check_eq("inicial_sem_iniciar", 32'(db_estado), 32'h0);

        // Full 16-round game
        run_game(-1, -1, -1, -1, -1, fc, wc);
        check_eq("completo_estado", 32'(fc), 32'hC);
        check_eq("completo_we", 32'(wc), 32'd15);
        check_eq("completo_pronto", 32'(pronto), 32'h1);
        check_eq("completo_acertou", 32'(acertou), 32'h1);

        // Miss at round 2, position 1
        run_game(2, 1, -1, -1, -1, fc, wc);
        check_eq("erro_estado", 32'(fc), 32'hD);
        check_eq("erro_we", 32'(wc), 32'd2);
        check_eq("erro_errou", 32'(errou), 32'h1);
        check_eq("erro_pronto", 32'(pronto), 32'h1);

        // Restart from fim_errou
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        check_eq("reinicio_estado1", 32'(db_estado), 32'h1);
        check_eq("reinicio_zeraRod", 32'(zeraRod), 32'h1);
        check_eq("reinicio_errou", 32'(errou), 32'h0);
        iniciar = 1'b0;
        @(negedge clock);
        check_eq("reinicio_estado2", 32'(db_estado), 32'h2);
        do_reset();

        // No play at round 1, position 1 while fimT is raised
        run_game(-1, -1, 1, 1, -1, fc, wc);
        check_eq("timeout_estado", 32'(fc), TMO_EN ? 32'hE : 32'h3);
        check_eq("timeout_we", 32'(wc), 32'd1);
        check_eq("timeout_saida", 32'(timeout), 32'(TMO_EN));
        if (!TMO_EN) do_reset();

        // Randomised games
        for (int g = 0; g < 6; g++) begin
            mode = $urandom_range(0, 2);
            r    = $urandom_range(0, 5);
            p    = $urandom_range(0, r);
            if (mode == 0) begin
                run_game(-1, -1, -1, -1, -1, fc, wc);
                check_eq("aleat_acerto_estado", 32'(fc), 32'hC);
                check_eq("aleat_acerto_we", 32'(wc), 32'd15);
            end else if (mode == 1) begin
                run_game(r, p, -1, -1, -1, fc, wc);
                check_eq("aleat_erro_estado", 32'(fc), 32'hD);
                check_eq("aleat_erro_we", 32'(wc), 32'(r));
            end else begin
                run_game(-1, -1, r, p, -1, fc, wc);
                check_eq("aleat_timeout_estado", 32'(fc), TMO_EN ? 32'hE : 32'h3);
                check_eq("aleat_timeout_we", 32'(wc), 32'(r));
                if (!TMO_EN) do_reset();
            end
        end

        // Asynchronous reset while waiting for a play and while writing
        run_game(-1, -1, -1, -1, 3, fc, wc);
        check_eq("abort_espera", 32'(fc), 32'h0);
        run_game(-1, -1, -1, -1, 10, fc, wc);
        check_eq("abort_escreve", 32'(fc), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
